// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt/trap controller: FSM encoding, CSR addresses,
// system instruction encodings and trap cause constants.
package int_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StMepc,
        StMstatus,
        StMcause,
        StJump,
        StMret
    } state_e;

    localparam logic [11:0] CsrMstatus = 12'h300;
    localparam logic [11:0] CsrMepc    = 12'h341;
    localparam logic [11:0] CsrMcause  = 12'h342;

    localparam logic [31:0] InstEcall  = 32'h0000_0073;
    localparam logic [31:0] InstEbreak = 32'h0010_0073;
    localparam logic [31:0] InstMret   = 32'h3020_0073;

    localparam int unsigned CauseEcall   = 11;
    localparam int unsigned CauseEbreak  = 3;
    localparam int unsigned CauseIrqBase = 16;

    localparam int unsigned MstatusMie  = 3;
    localparam int unsigned MstatusMpie = 7;

endpackage

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: reports whether any request is set and the lowest set index.
module int_prio_enc #(
    parameter int unsigned NUM_IRQ = 8,
    parameter int unsigned IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic [NUM_IRQ-1:0] req_i,
    output logic               valid_o,
    output logic [IDX_W-1:0]   idx_o
);

    // Scan downwards so the lowest set index is the last one written.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                valid_o = 1'b1;
                idx_o   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Machine-mode trap/interrupt sequencer: saves mepc/mstatus/mcause and redirects the PC.
// Define INT_CTRL_VECTORED_EN to honour vectored mtvec mode for asynchronous interrupts.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int unsigned NUM_IRQ = 8,
    parameter int unsigned XLEN    = 32,
    parameter int unsigned CSR_AW  = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_IRQ-1:0]  irq_i,
    input  logic [NUM_IRQ-1:0]  mie_i,
    input  logic [XLEN-1:0]     inst_i,
    input  logic [XLEN-1:0]     inst_addr_i,
    input  logic                jump_flag_i,
    input  logic [XLEN-1:0]     jump_addr_i,
    input  logic [XLEN-1:0]     mtvec_i,
    input  logic [XLEN-1:0]     mepc_i,
    input  logic [XLEN-1:0]     mstatus_i,
    output logic                hold_o,
    output logic                csr_we_o,
    output logic [CSR_AW-1:0]   csr_waddr_o,
    output logic [XLEN-1:0]     csr_wdata_o,
    output logic                int_assert_o,
    output logic [XLEN-1:0]     int_addr_o,
    output logic [NUM_IRQ-1:0]  irq_ack_o
);

    localparam int unsigned IdxW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   epc_q, epc_d;
    logic [XLEN-1:0]   cause_q, cause_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              async_q, async_d;
    logic              mret_q, mret_d;

    logic              enc_valid;
    logic [IdxW-1:0]   enc_idx;
    logic              is_ecall, is_ebreak, is_mret;
    logic              sync_trap, irq_pend, event_in_idle;
    logic [XLEN-1:0]   trap_base, trap_target;
    logic [XLEN-1:0]   mstatus_trap, mstatus_mret;

    int_prio_enc #(
        .NUM_IRQ (NUM_IRQ),
        .IDX_W   (IdxW)
    ) u_prio_enc (
        .req_i   (irq_i & mie_i),
        .valid_o (enc_valid),
        .idx_o   (enc_idx)
    );

    assign is_ecall      = (inst_i[31:0] == InstEcall);
    assign is_ebreak     = (inst_i[31:0] == InstEbreak);
    assign is_mret       = (inst_i[31:0] == InstMret);
    assign sync_trap     = is_ecall | is_ebreak;
    assign irq_pend      = enc_valid & mstatus_i[MstatusMie];
    assign event_in_idle = (state_q == StIdle) & (sync_trap | irq_pend | is_mret);

    assign trap_base = {mtvec_i[XLEN-1:2], 2'b00};

`ifdef INT_CTRL_VECTORED_EN
    always_comb begin
        trap_target = trap_base;
        if (async_q && (mtvec_i[1:0] == 2'b01)) begin
            trap_target = trap_base + XLEN'((CauseIrqBase + 32'(idx_q)) << 2);
        end
    end
`else
    logic unused_mtvec_mode;
    assign unused_mtvec_mode = ^mtvec_i[1:0];
    assign trap_target       = trap_base;
`endif

    always_comb begin
        mstatus_trap              = mstatus_i;
        mstatus_trap[MstatusMpie] = mstatus_i[MstatusMie];
        mstatus_trap[MstatusMie]  = 1'b0;
        mstatus_trap[12:11]       = 2'b11;
        mstatus_mret              = mstatus_i;
        mstatus_mret[MstatusMie]  = mstatus_i[MstatusMpie];
        mstatus_mret[MstatusMpie] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            epc_q   <= '0;
            cause_q <= '0;
            idx_q   <= '0;
            async_q <= 1'b0;
            mret_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            idx_q   <= idx_d;
            async_q <= async_d;
            mret_q  <= mret_d;
        end
    end

    // Events are only sampled in StIdle; anything arriving mid-sequence is dropped.
    always_comb begin
        state_d = state_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        idx_d   = idx_q;
        async_d = async_q;
        mret_d  = mret_q;
        unique case (state_q)
            StIdle: begin
                if (sync_trap) begin
                    state_d = StMepc;
                    epc_d   = inst_addr_i;
                    cause_d = is_ecall ? XLEN'(CauseEcall) : XLEN'(CauseEbreak);
                    idx_d   = '0;
                    async_d = 1'b0;
                    mret_d  = 1'b0;
                end else if (irq_pend) begin
                    state_d = StMepc;
                    epc_d   = jump_flag_i ? jump_addr_i : inst_addr_i;
                    cause_d = {1'b1, (XLEN-1)'(CauseIrqBase + 32'(enc_idx))};
                    idx_d   = enc_idx;
                    async_d = 1'b1;
                    mret_d  = 1'b0;
                end else if (is_mret) begin
                    state_d = StMret;
                    async_d = 1'b0;
                    mret_d  = 1'b1;
                end
            end
            StMepc:    state_d = StMstatus;
            StMstatus: state_d = StMcause;
            StMcause:  state_d = StJump;
            StMret:    state_d = StJump;
            StJump:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Outputs are forced quiet during reset so an aborted sequence emits nothing further.
    always_comb begin
        hold_o       = event_in_idle | (~rst & (state_q != StIdle));
        csr_we_o     = 1'b0;
        csr_waddr_o  = '0;
        csr_wdata_o  = '0;
        int_assert_o = 1'b0;
        int_addr_o   = '0;
        irq_ack_o    = '0;
        if (!rst) begin
            unique case (state_q)
                StMepc: begin
                    csr_we_o    = 1'b1;
                    csr_waddr_o = CSR_AW'(CsrMepc);
                    csr_wdata_o = epc_q;
                end
                StMstatus: begin
                    csr_we_o    = 1'b1;
                    csr_waddr_o = CSR_AW'(CsrMstatus);
                    csr_wdata_o = mstatus_trap;
                end
                StMcause: begin
                    csr_we_o    = 1'b1;
                    csr_waddr_o = CSR_AW'(CsrMcause);
                    csr_wdata_o = cause_q;
                end
                StMret: begin
                    csr_we_o    = 1'b1;
                    csr_waddr_o = CSR_AW'(CsrMstatus);
                    csr_wdata_o = mstatus_mret;
                end
                StJump: begin
                    int_assert_o = 1'b1;
                    int_addr_o   = mret_q ? mepc_i : trap_target;
                    if (async_q) begin
                        irq_ack_o = NUM_IRQ'(1) << idx_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
